// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster timing generator with frame-paced colour rotate index
module vga_timing_ctrl #(
  parameter int H_VIS           = 640,
  parameter int H_FP            = 16,
  parameter int H_SW            = 96,
  parameter int H_BP            = 48,
  parameter int V_VIS           = 480,
  parameter int V_FP            = 10,
  parameter int V_SW            = 2,
  parameter int V_BP            = 33,
  parameter int FRAMES_PER_STEP = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rotate_hold,
  output logic       pix_tick,
  output logic [9:0] x_ord,
  output logic [9:0] y_ord,
  output logic       visible,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_end,
  output logic [1:0] rotate
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_W    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W    = 10'(V_VIS);
  localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SW);
  localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SW);
  localparam logic [9:0] FRAME_LAST = 10'(FRAMES_PER_STEP - 1);

  logic       phase;
  logic [9:0] frame_cnt;

  // Strobes are gated by enable so a frozen generator emits no ticks or frame pulses.
  assign pix_tick  = phase & enable;
  assign frame_end = pix_tick && (x_ord == H_LAST) && (y_ord == V_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= 1'b0;
      x_ord     <= '0;
      y_ord     <= '0;
      frame_cnt <= '0;
      rotate    <= '0;
    end else if (enable) begin
      phase <= ~phase;
      if (phase) begin
        if (x_ord == H_LAST) begin
          x_ord <= '0;
          y_ord <= (y_ord == V_LAST) ? 10'd0 : y_ord + 10'd1;
        end else begin
          x_ord <= x_ord + 10'd1;
        end
      end
      if (frame_end && !rotate_hold) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          rotate    <= rotate + 2'd1;
        end else begin
          frame_cnt <= frame_cnt + 10'd1;
        end
      end
    end
  end

  assign visible = (x_ord < H_VIS_W) && (y_ord < V_VIS_W);
  assign hsync   = !((x_ord >= HS_START) && (x_ord < HS_END));
  assign vsync   = !((y_ord >= VS_START) && (y_ord < VS_END));

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - scoreboard bench for vga_timing_ctrl on a shrunken raster
module tb_vga_timing_ctrl;

  localparam int H_VIS = 8, H_FP = 2, H_SW = 3, H_BP = 3;
  localparam int V_VIS = 4, V_FP = 1, V_SW = 2, V_BP = 1;
  localparam int FPS   = 2;
  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       rotate_hold = 1'b0;
  logic       pix_tick, visible, hsync, vsync, frame_end;
  logic [9:0] x_ord, y_ord;
  logic [1:0] rotate;

  vga_timing_ctrl #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP),
    .FRAMES_PER_STEP(FPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rotate_hold(rotate_hold),
    .pix_tick(pix_tick), .x_ord(x_ord), .y_ord(y_ord), .visible(visible),
    .hsync(hsync), .vsync(vsync), .frame_end(frame_end), .rotate(rotate)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       vis, hs, vs, fe;
    logic [1:0] rot;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: linear pixel index over the frame, plus phase and rotate bookkeeping.
  bit m_phase = 0;
  int m_pix = 0, m_fcnt = 0, m_rot = 0;

  int cyc = 0, n_fe = 0, last_fe_cyc = -1;
  bit track_gap = 0;
  int gaps[$];
  int hs_run = 0, vs_run = 0;
  int hs_lens[$];
  int vs_lens[$];
  int x_save, y_save;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit en, input bit hold, input bit rn);
    exp_t e;
    int   mx, my;
    @(negedge clk);
    enable = en; rotate_hold = hold; rst_n = rn;
    mx    = m_pix % H_TOT;
    my    = m_pix / H_TOT;
    e.pt  = en && m_phase;
    e.x   = 10'(mx);
    e.y   = 10'(my);
    e.vis = (mx < H_VIS) && (my < V_VIS);
    e.hs  = !((mx >= H_VIS + H_FP) && (mx < H_VIS + H_FP + H_SW));
    e.vs  = !((my >= V_VIS + V_FP) && (my < V_VIS + V_FP + V_SW));
    e.fe  = e.pt && (m_pix == FRAME - 1);
    e.rot = 2'(m_rot);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk("pix_tick", pix_tick, e.pt);
    chk("x_ord", x_ord, e.x);
    chk("y_ord", y_ord, e.y);
    chk("visible", visible, e.vis);
    chk("hsync", hsync, e.hs);
    chk("vsync", vsync, e.vs);
    chk("frame_end", frame_end, e.fe);
    chk("rotate", rotate, e.rot);
    if (frame_end === 1'b1) begin
      if (track_gap && last_fe_cyc >= 0) gaps.push_back(cyc - last_fe_cyc);
      last_fe_cyc = cyc;
      n_fe++;
    end
    if (hsync === 1'b0) hs_run++;
    else if (hs_run > 0) begin hs_lens.push_back(hs_run); hs_run = 0; end
    if (vsync === 1'b0) vs_run++;
    else if (vs_run > 0) begin vs_lens.push_back(vs_run); vs_run = 0; end
    cyc++;
    if (!rn) begin
      m_phase = 0; m_pix = 0; m_fcnt = 0; m_rot = 0;
    end else if (en) begin
      if (e.fe && !hold) begin
        m_fcnt++;
        if (m_fcnt == FPS) begin m_fcnt = 0; m_rot = (m_rot + 1) % 4; end
      end
      if (m_phase) m_pix = (m_pix + 1) % FRAME;
      m_phase = !m_phase;
    end
  endtask

  task automatic run_frames(input int n, input bit hold);
    int target = n_fe + n;
    int budget = n * 2 * FRAME + 8;
    while (n_fe < target && budget > 0) begin cycle(1, hold, 1); budget--; end
    chk("frame_budget", n_fe, target);
    cycle(1, hold, 1);
  endtask

  // Advance until the DUT shows x_ord == x-1 with pix_tick high, so the next state is x with phase 0.
  task automatic run_to(input int x, input int y, input bit hold);
    int budget = 2 * FRAME + 4;
    while (!(x_ord == 10'(x - 1) && y_ord == 10'(y) && pix_tick) && budget > 0) begin
      cycle(1, hold, 1); budget--;
    end
    chk("run_to_budget", budget > 0, 1);
    cycle(1, hold, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);

    // Reset state, still disabled
    cycle(0, 0, 1);
    chk("rst_pix_tick", pix_tick, 0);
    chk("rst_visible", visible, 1);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_frame_end", frame_end, 0);
    chk("rst_rotate", rotate, 0);

    // First pixels after enable
    cycle(1, 0, 1);
    cycle(1, 0, 1);
    chk("edge1_pix_tick", pix_tick, 1);
    cycle(1, 0, 1);
    chk("edge2_pix_tick", pix_tick, 0);
    chk("edge2_x", x_ord, 1);
    cycle(1, 0, 1);
    cycle(1, 0, 1);
    chk("edge4_x", x_ord, 2);

    // Freeze mid-line for 37 clocks
    run_to(5, 0, 0);
    x_save = x_ord; y_save = y_ord;
    repeat (37) cycle(0, 0, 1);
    chk("frozen_x", x_ord, x_save);
    chk("frozen_y", y_ord, y_save);
    begin
      int budget = 4;
      while (x_ord == 10'(x_save) && budget > 0) begin cycle(1, 0, 1); budget--; end
      chk("resume_x", x_ord, x_save + 1);
    end

    // Frame pacing and rotate stepping, then hold
    track_gap = 1; last_fe_cyc = -1;
    run_frames(2, 0); chk("rot_after_2", rotate, 1);
    run_frames(2, 0); chk("rot_after_4", rotate, 2);
    run_frames(2, 0); chk("rot_after_6", rotate, 3);
    run_frames(2, 0); chk("rot_after_8", rotate, 0);
    run_frames(4, 1); chk("rot_held_12", rotate, 0);
    track_gap = 0;
    chk("gap_count", gaps.size(), 11);
    foreach (gaps[i]) chk("frame_period", gaps[i], 2 * FRAME);
    chk("hsync_runs_seen", hs_lens.size() > 0, 1);
    if (hs_lens.size() > 0) chk("hsync_low_clks", hs_lens[hs_lens.size() - 1], 2 * H_SW);
    chk("vsync_runs_seen", vs_lens.size() > 0, 1);
    if (vs_lens.size() > 0) chk("vsync_low_clks", vs_lens[vs_lens.size() - 1], 2 * H_TOT * V_SW);

    // Random enable gaps: no skipped or repeated pixels
    for (int i = 0; i < 400; i++) cycle(1'($urandom_range(0, 1)), 1, 1);

    // Reset in the middle of a sync pulse with a non-zero rotate
    run_frames(4, 0);
    chk("rot_before_reset", rotate, 2);
    run_to(12, 6, 0);
    chk("pre_rst_hsync", hsync, 0);
    chk("pre_rst_vsync", vsync, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 1);
    chk("post_rst_x", x_ord, 0);
    chk("post_rst_y", y_ord, 0);
    chk("post_rst_rotate", rotate, 0);
    chk("post_rst_hsync", hsync, 1);
    chk("post_rst_vsync", vsync, 1);
    chk("post_rst_frame_end", frame_end, 0);
    repeat (6) cycle(1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
